// File: rtl/instr_dispatch_fifo.sv
// rtl/instr_dispatch_fifo.sv - host instruction FIFO issuing one word at a time to the matrix coprocessor
// Optional build macro: OPCODE_CHECK_EN (adds sticky illegal output and opcode filtering on push)
module instr_dispatch_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       host_instr,
    input  logic              host_wr,
    input  logic              host_clear,
    output logic              host_full,
    output logic [ADDR_W:0]   host_count,
    output logic              overflow,
    input  logic              cop_done,
    output logic [31:0]       instruction,
    output logic              activate_instruction,
`ifdef OPCODE_CHECK_EN
    output logic              illegal,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [31:0]         mem_q [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         instr_q, instr_d;
    logic                ovf_q, ovf_d;
    logic                pop;
    logic                push;
    logic                full;
    logic                wr_attempt;
    logic                opc_ok;
`ifdef OPCODE_CHECK_EN
    logic                ill_q, ill_d;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (count_q != '0) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cop_done) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        pop                  = (state_q == S_IDLE) && (count_q != '0);
        activate_instruction = (state_q == S_ISSUE);
        busy                 = (state_q != S_IDLE) || (count_q != '0);
    end

    // ---------------- push qualification ----------------
`ifdef OPCODE_CHECK_EN
    assign opc_ok = (host_instr[3:0] != 4'd0) && (host_instr[3:0] <= 4'd12);
`else
    assign opc_ok = 1'b1;
`endif

    assign full       = (count_q == FULL_CNT);
    assign wr_attempt = host_wr && !host_clear;
    // A pop in the same cycle frees the head slot, so a full FIFO can still take the word.
    assign push       = wr_attempt && opc_ok && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        instr_d  = instr_q;
        if (pop) begin
            instr_d  = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (wr_attempt && opc_ok && full && !pop) begin
            ovf_d = 1'b1;
        end
        // Flush leaves the FSM and instruction register alone so an in-flight op completes.
        if (host_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

`ifdef OPCODE_CHECK_EN
    always_comb begin
        ill_d = ill_q;
        if (wr_attempt && !opc_ok) begin
            ill_d = 1'b1;
        end
        if (host_clear) begin
            ill_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= ill_d;
        end
    end

    assign illegal = ill_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            instr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            instr_q  <= instr_d;
        end
    end

    // Storage array needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= host_instr;
        end
    end

    assign host_full   = full;
    assign host_count  = count_q;
    assign overflow    = ovf_q;
    assign instruction = instr_q;

endmodule

// File: tb/tb_instr_dispatch_fifo.sv
// tb/tb_instr_dispatch_fifo.sv - randomized self-checking bench for instr_dispatch_fifo
// Optional build macro: OPCODE_CHECK_EN
module tb_instr_dispatch_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              reset_n;
    logic [31:0]       host_instr;
    logic              host_wr;
    logic              host_clear;
    logic              host_full;
    logic [ADDR_W:0]   host_count;
    logic              overflow;
    logic              cop_done;
    logic [31:0]       instruction;
    logic              activate_instruction;
    logic              illegal;
    logic              busy;

    instr_dispatch_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .host_instr           (host_instr),
        .host_wr              (host_wr),
        .host_clear           (host_clear),
        .host_full            (host_full),
        .host_count           (host_count),
        .overflow             (overflow),
        .cop_done             (cop_done),
        .instruction          (instruction),
        .activate_instruction (activate_instruction),
`ifdef OPCODE_CHECK_EN
        .illegal              (illegal),
`endif
        .busy                 (busy)
    );

`ifndef OPCODE_CHECK_EN
    assign illegal = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a word queue plus the edge numbers at which issue is allowed.
    logic [31:0] q[$];
    logic [31:0] m_instr;
    bit          m_awaiting;
    int          m_done_from;
    int          m_next_pop;
    int          m_last_pop;
    bit          m_ovf;
    bit          m_ill;
    int          edge_n;

    function automatic bit opcode_legal(input logic [31:0] w);
`ifdef OPCODE_CHECK_EN
        logic [3:0] op;
        op = w[3:0];
        return (op != 4'd0) && (op <= 4'd12);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_instr     = '0;
        m_awaiting  = 0;
        m_done_from = 0;
        m_next_pop  = 0;
        m_last_pop  = -1;
        m_ovf       = 0;
        m_ill       = 0;
        edge_n      = 0;
    endtask

    task automatic model_edge();
        bit do_pop;
        edge_n++;
        do_pop = !m_awaiting && (edge_n >= m_next_pop) && (q.size() > 0);
        // Completion is only honoured once the issue pulse has finished.
        if (m_awaiting && edge_n >= m_done_from && cop_done) begin
            m_awaiting = 0;
            m_next_pop = edge_n + 2;
        end
        if (do_pop) begin
            m_instr     = q.pop_front();
            m_awaiting  = 1;
            m_done_from = edge_n + 2;
            m_last_pop  = edge_n;
        end
        if (host_clear) begin
            q.delete();
            m_ovf = 0;
            m_ill = 0;
        end else if (host_wr) begin
            if (!opcode_legal(host_instr)) m_ill = 1;
            else if (q.size() < DEPTH) q.push_back(host_instr);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        bit exp_busy;
        exp_busy = m_awaiting || (edge_n + 1 < m_next_pop) || (q.size() != 0);
        check_eq("instruction", instruction, m_instr);
        check_eq("activate", 32'(activate_instruction), 32'(edge_n == m_last_pop));
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("host_count", 32'(host_count), 32'(q.size()));
        check_eq("host_full", 32'(host_full), 32'(q.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
`ifdef OPCODE_CHECK_EN
        check_eq("illegal", 32'(illegal), 32'(m_ill));
`endif
    endtask

    task automatic cyc(input logic wr, input logic [31:0] d, input logic done, input logic clr);
        host_wr    = wr;
        host_instr = d;
        cop_done   = done;
        host_clear = clr;
        @(posedge clk);
        if (!reset_n) model_reset();
        else model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        reset_n    = 1'b0;
        host_wr    = 1'b0;
        host_instr = '0;
        host_clear = 1'b0;
        cop_done   = 1'b0;
        model_reset();
        idle(3);
        check_eq("rst_count", 32'(host_count), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle(2);

        // single issue and its latency
        cyc(1'b1, 32'h0000_0013, 1'b0, 1'b0);
        check_eq("t1_act_early", 32'(activate_instruction), 32'd0);
        idle(1);
        check_eq("t1_act", 32'(activate_instruction), 32'd1);
        check_eq("t1_instr", instruction, 32'h13);
        idle(1);
        check_eq("t1_act_off", 32'(activate_instruction), 32'd0);
        idle(2);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t1_busy_gap", 32'(busy), 32'd1);
        idle(1);
        check_eq("t1_busy_idle", 32'(busy), 32'd0);

        // three queued words, completions spaced out
        cyc(1'b1, 32'h0000_0021, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0032, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0043, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(3);
            cyc(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check_eq("t2_last_instr", instruction, 32'h43);
        idle(3);

        // fill to full while waiting on the coprocessor
        for (int k = 0; k < 9; k++) cyc(1'b1, 32'h0000_0101 + 32'(k << 4), 1'b0, 1'b0);
        check_eq("t3_full", 32'(host_full), 32'd1);
        check_eq("t3_count", 32'(host_count), 32'd8);
        check_eq("t3_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        idle(1);
        cyc(1'b1, 32'h0000_0AA1, 1'b0, 1'b0);
        check_eq("t4_count", 32'(host_count), 32'd8);
        check_eq("t4_ovf", 32'(overflow), 32'd0);
        check_eq("t4_instr", instruction, 32'h0000_0111);
        cyc(1'b1, 32'h0000_0BB2, 1'b0, 1'b0);
        check_eq("t3_ovf_set", 32'(overflow), 32'd1);
        check_eq("t3_count_hold", 32'(host_count), 32'd8);
        idle(2);

        // flush during WAIT, push in the same cycle is dropped
        cyc(1'b1, 32'h0000_0CC3, 1'b0, 1'b1);
        check_eq("t5_count", 32'(host_count), 32'd0);
        check_eq("t5_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        idle(5);
        check_eq("t5_busy", 32'(busy), 32'd0);

`ifdef OPCODE_CHECK_EN
        cyc(1'b1, 32'h0000_000F, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0005, 1'b0, 1'b0);
        idle(2);
        check_eq("t6_illegal", 32'(illegal), 32'd1);
        check_eq("t6_instr", instruction, 32'h5);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        idle(3);
`endif

        // asynchronous reset while waiting
        cyc(1'b1, 32'h0000_0077, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0088, 1'b0, 1'b0);
        idle(2);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("rst_async_instr", instruction, 32'h0);
        idle(2);
        reset_n = 1'b1;
        idle(2);

        // randomized traffic: first phase biased toward filling, second toward draining
        for (int i = 0; i < 3000; i++) begin
            logic        wr, dn, cl;
            logic [31:0] w;
            if (i < 1500) begin
                wr = ($urandom_range(0, 99) < 70);
                dn = ($urandom_range(0, 99) < 10);
            end else begin
                wr = ($urandom_range(0, 99) < 30);
                dn = ($urandom_range(0, 99) < 40);
            end
            cl = ($urandom_range(0, 99) < 2);
            w  = $urandom;
            cyc(wr, w, dn, cl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
